// File: rtl/pll_rst_seq_if.sv
// pll_rst_seq_if
//   Groups the PLL supervisor's control and status signals so that the
//   sequencer and its environment connect through one bundle.
//
//   Signals:
//     restart_req  supervisor <- env  single-cycle request for a full re-sequence
//     pll_lock     supervisor <- PLL  raw LOCK, asynchronous to clk
//     pll_reset_n  supervisor -> PLL  RESETB, registered
//     rst_stage    supervisor -> env  active-high domain resets, bit 0 released first
//     ready        supervisor -> env  high only while running
//     fail         supervisor -> env  high only after retries are exhausted
//     lock_lost    supervisor -> env  one-cycle pulse when lock drops while running
//     retry_cnt    supervisor -> env  failed attempts in the current sequence
//     dbg_state    supervisor -> env  current sequencer state (debug visibility)
//
//   Protocol: there is no valid/ready handshake in this bundle. restart_req is a
//   fire-and-forget pulse that is always accepted on the clk edge at which it is
//   high. pll_lock is level-sensitive and is synchronised inside the sequencer.
//   Every output is a registered level except lock_lost, which is a registered
//   one-cycle pulse.
interface pll_rst_seq_if #(
  parameter int N_STAGES = 2
);
  logic                restart_req;
  logic                pll_lock;
  logic                pll_reset_n;
  logic [N_STAGES-1:0] rst_stage;
  logic                ready;
  logic                fail;
  logic                lock_lost;
  logic [3:0]          retry_cnt;
  logic [2:0]          dbg_state;

  // Environment side (testbench / system controller).
  modport master (
    output restart_req, pll_lock,
    input  pll_reset_n, rst_stage, ready, fail, lock_lost, retry_cnt, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  restart_req, pll_lock,
    output pll_reset_n, rst_stage, ready, fail, lock_lost, retry_cnt, dbg_state
  );
endinterface

// File: rtl/pll_rst_seq.sv
// pll_rst_seq
//   PLL supervisor and staged reset sequencer. Holds the PLL in reset, waits
//   for a qualified lock (with timeout and bounded retry), requires lock to be
//   stable for a settle window, then releases the domain resets one by one
//   with a fixed spacing. While running, a loss of lock re-sequences
//   everything; restart_req forces a re-sequence from any state.
//
//   Ports:
//     clk    in  free-running reference clock
//     rst_n  in  asynchronous active-low reset
//     bus    pll_rst_seq_if.slave (see the interface file for signal list)
module pll_rst_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 256,
  parameter int N_STAGES      = 2,
  parameter int STAGE_GAP     = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  pll_rst_seq_if.slave  bus
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (SETTLE_CYCLES > N_STAGES * STAGE_GAP) ? SETTLE_CYCLES
                                                                  : N_STAGES * STAGE_GAP;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST    = CW'(N_STAGES * STAGE_GAP - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_FAIL      = 3'd5;

  logic [1:0]          r_sync;
  logic [2:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_retry;
  logic                r_pll_reset_n;
  logic [N_STAGES-1:0] r_rst_stage;
  logic                r_ready;
  logic                r_fail;
  logic                r_lock_lost;

  logic                w_lock_s;
  logic [2:0]          w_next_state;
  logic [3:0]          w_next_retry;
  logic                w_state_entry;
  logic [N_STAGES-1:0] w_next_stage;

  // Only the second synchroniser flop is ever used for decisions.
  assign w_lock_s = r_sync[1];

  always_comb begin
    w_next_state = r_state;
    w_next_retry = r_retry;
    if (bus.restart_req) begin
      // Restart wins over every other transition, including a coincident timeout.
      w_next_state = S_PLL_RST;
      w_next_retry = 4'd0;
    end else begin
      case (r_state)
        S_PLL_RST: begin
          if (r_cnt == RST_LAST) w_next_state = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_next_state = S_SETTLE;
          end else if (r_cnt == LOCK_LAST) begin
            if (r_retry == RETRY_MAX) begin
              w_next_state = S_FAIL;
            end else begin
              w_next_state = S_PLL_RST;
              w_next_retry = r_retry + 4'd1;
            end
          end
        end
        S_SETTLE: begin
          if (!w_lock_s)                w_next_state = S_WAIT_LOCK;
          else if (r_cnt == SETTLE_LAST) w_next_state = S_RELEASE;
        end
        S_RELEASE: begin
          if (!w_lock_s)              w_next_state = S_PLL_RST;
          else if (r_cnt == REL_LAST) w_next_state = S_RUN;
        end
        S_RUN: begin
          if (!w_lock_s) w_next_state = S_PLL_RST;
        end
        S_FAIL: begin
          w_next_state = S_FAIL;
        end
        default: begin
          w_next_state = S_PLL_RST;
        end
      endcase
      if (w_next_state == S_RUN) w_next_retry = 4'd0;
    end
  end

  // A restart while already in PLL_RST counts as a fresh entry.
  assign w_state_entry = (w_next_state != r_state) || bus.restart_req;

  // Stage resets: all-asserted outside RELEASE/RUN, all-released in RUN, and
  // inside RELEASE each bit drops once the counter passes its slot. Bits only
  // clear relative to their previous value, so release order is monotonic.
  always_comb begin
    w_next_stage = '1;
    if (w_next_state == S_RUN) begin
      w_next_stage = '0;
    end else if (r_state == S_RELEASE && w_next_state == S_RELEASE) begin
      w_next_stage = r_rst_stage;
      for (int i = 0; i < N_STAGES; i++) begin
        if (r_cnt == CW'(i * STAGE_GAP)) w_next_stage[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync        <= 2'b00;
      r_state       <= S_PLL_RST;
      r_cnt         <= '0;
      r_retry       <= 4'd0;
      r_pll_reset_n <= 1'b0;
      r_rst_stage   <= '1;
      r_ready       <= 1'b0;
      r_fail        <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.pll_lock};
      r_state <= w_next_state;
      r_retry <= w_next_retry;
      if (w_state_entry)                       r_cnt <= '0;
      else if (r_state != S_RUN && r_state != S_FAIL) r_cnt <= r_cnt + 1'b1;
      r_pll_reset_n <= (w_next_state != S_PLL_RST) && (w_next_state != S_FAIL);
      r_rst_stage   <= w_next_stage;
      r_ready       <= (w_next_state == S_RUN);
      r_fail        <= (w_next_state == S_FAIL);
      r_lock_lost   <= !bus.restart_req && (r_state == S_RUN) && !w_lock_s;
    end
  end

  assign bus.pll_reset_n = r_pll_reset_n;
  assign bus.rst_stage   = r_rst_stage;
  assign bus.ready       = r_ready;
  assign bus.fail        = r_fail;
  assign bus.lock_lost   = r_lock_lost;
  assign bus.retry_cnt   = r_retry;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq
//   Directed and randomized stimulus for pll_rst_seq, with a behavioural model
//   that tracks the sequence phase and the time spent in it and derives the
//   expected outputs arithmetically.
module tb_pll_rst_seq;
  localparam int RST_CYCLES    = 16;
  localparam int LOCK_TIMEOUT  = 4096;
  localparam int SETTLE_CYCLES = 256;
  localparam int N_STAGES      = 2;
  localparam int STAGE_GAP     = 8;
  localparam int MAX_RETRY     = 3;
  localparam int VW            = N_STAGES + 8;
  localparam int ALL_ONES      = (1 << N_STAGES) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pll_rst_seq_if #(.N_STAGES(N_STAGES)) bus();

  pll_rst_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .N_STAGES     (N_STAGES),
    .STAGE_GAP    (STAGE_GAP),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int last_edge = -1;

  // ---------------- reference model ----------------
  typedef enum int {M_RST, M_WAIT, M_SETTLE, M_REL, M_RUN, M_FAIL} mode_e;
  mode_e m_mode;
  int    m_t;
  int    m_tries;
  logic  m_lost;
  logic  lock_hist[$];
  logic [VW-1:0] exp_q[$];

  task automatic model_reset();
    m_mode = M_RST; m_t = 0; m_tries = 0; m_lost = 1'b0;
    lock_hist.delete();
    lock_hist.push_back(1'b0);
    lock_hist.push_back(1'b0);
  endtask

  task automatic enter(input mode_e m);
    m_mode = m; m_t = 0;
  endtask

  task automatic model_step(input logic lk, input logic rq);
    logic ls;
    ls = lock_hist.pop_front();
    lock_hist.push_back(lk);
    m_lost = 1'b0;
    if (rq) begin
      enter(M_RST); m_tries = 0;
    end else begin
      case (m_mode)
        M_RST:    if (m_t == RST_CYCLES - 1) enter(M_WAIT); else m_t++;
        M_WAIT:   if (ls) enter(M_SETTLE);
                  else if (m_t == LOCK_TIMEOUT - 1) begin
                    if (m_tries == MAX_RETRY) enter(M_FAIL);
                    else begin m_tries++; enter(M_RST); end
                  end else m_t++;
        M_SETTLE: if (!ls) enter(M_WAIT);
                  else if (m_t == SETTLE_CYCLES - 1) enter(M_REL); else m_t++;
        M_REL:    if (!ls) enter(M_RST);
                  else if (m_t == N_STAGES * STAGE_GAP - 1) begin enter(M_RUN); m_tries = 0; end
                  else m_t++;
        M_RUN:    if (!ls) begin m_lost = 1'b1; enter(M_RST); end
        default:  ;
      endcase
    end
  endtask

  function automatic logic [VW-1:0] model_outputs();
    logic [N_STAGES-1:0] st;
    st = '1;
    if (m_mode == M_RUN) st = '0;
    else if (m_mode == M_REL)
      for (int i = 0; i < N_STAGES; i++) if (m_t > i * STAGE_GAP) st[i] = 1'b0;
    return {(m_mode != M_RST && m_mode != M_FAIL), st, (m_mode == M_RUN),
            (m_mode == M_FAIL), m_lost, 4'(m_tries)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [VW-1:0] obs;
    logic [VW-1:0] exp;
    exp_q.push_back(model_outputs());
    exp = exp_q.pop_front();
    obs = {bus.pll_reset_n, bus.rst_stage, bus.ready, bus.fail, bus.lock_lost, bus.retry_cnt};
    if (errors < 50) check("outputs", 32'(obs), 32'(exp));
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge; the DUT samples them at the next
  // rising edge and outputs are checked at the following falling edge.
  task automatic cyc(input logic lk, input logic rq);
    bus.pll_lock    = lk;
    bus.restart_req = rq;
    @(posedge clk);
    model_step(lk, rq);
    last_edge++;
    @(negedge clk);
    check_outputs();
    bus.restart_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_reset_n"}, 32'(bus.pll_reset_n), 0);
    check({tag, "_rst_stage"},   32'(bus.rst_stage),   ALL_ONES);
    check({tag, "_ready"},       32'(bus.ready),       0);
    check({tag, "_fail"},        32'(bus.fail),        0);
    check({tag, "_lock_lost"},   32'(bus.lock_lost),   0);
    check({tag, "_retry"},       32'(bus.retry_cnt),   0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int lock_edge, t_s0, t_s1, t_rdy, n, r_edge, drop_left;
    logic rq_v, lk_v, hit;

    bus.pll_lock = 1'b0;
    bus.restart_req = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Boot with lock arriving at edge 40.
    for (int k = 0; k < 40; k++) cyc(1'b0, 1'b0);
    lock_edge = last_edge + 1;
    t_s0 = -1; t_s1 = -1; t_rdy = -1;
    for (int k = 0; k < 400 && t_rdy < 0; k++) begin
      cyc(1'b1, 1'b0);
      if (t_s0 < 0 && bus.rst_stage[0] === 1'b0) t_s0 = last_edge;
      if (t_s1 < 0 && bus.rst_stage[1] === 1'b0) t_s1 = last_edge;
      if (t_rdy < 0 && bus.ready === 1'b1) t_rdy = last_edge;
    end
    check("boot_stage0_delay", 32'(t_s0 - lock_edge), 2 + SETTLE_CYCLES + 1);
    check("boot_stage1_gap", 32'(t_s1 - t_s0), STAGE_GAP);
    check("boot_ready_gap", 32'(t_rdy - t_s1),
          N_STAGES * STAGE_GAP - ((N_STAGES - 1) * STAGE_GAP + 1));

    // Lock loss while running.
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0);
    n = 0;
    while (bus.lock_lost !== 1'b1 && n < 10) begin cyc(1'b0, 1'b0); n++; end
    check("loss_pulse_seen", 32'(bus.lock_lost), 1);
    check("loss_stage", 32'(bus.rst_stage), ALL_ONES);
    check("loss_ready", 32'(bus.ready), 0);
    cyc(1'b0, 1'b0);
    check("loss_pulse_single", 32'(bus.lock_lost), 0);
    for (int k = 0; k < 30; k++) cyc(1'b0, 1'b0);
    n = 0;
    while (bus.ready !== 1'b1 && n < 600) begin cyc(1'b1, 1'b0); n++; end
    check("loss_recover_ready", 32'(bus.ready), 1);

    // Flaky lock in the middle of the settle window.
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 30; k++)  cyc(1'b0, 1'b0);
    for (int k = 0; k < 130; k++) cyc(1'b1, 1'b0);
    for (int k = 0; k < 3; k++)   cyc(1'b0, 1'b0);
    lock_edge = last_edge + 1;
    t_s0 = -1;
    for (int k = 0; k < 400 && t_s0 < 0; k++) begin
      cyc(1'b1, 1'b0);
      if (bus.rst_stage[0] === 1'b0) t_s0 = last_edge;
    end
    check("flaky_settle_restart", 32'(t_s0 - lock_edge), 2 + SETTLE_CYCLES + 1);
    check("flaky_retry", 32'(bus.retry_cnt), 0);

    // No lock ever: four attempts, then FAIL.
    cyc(1'b0, 1'b1);
    r_edge = last_edge;
    n = 0;
    while (bus.fail !== 1'b1 && n < 17000) begin cyc(1'b0, 1'b0); n++; end
    check("nolock_fail_time", 32'(last_edge - r_edge),
          (MAX_RETRY + 1) * (RST_CYCLES + LOCK_TIMEOUT));
    check("nolock_pll_reset_n", 32'(bus.pll_reset_n), 0);
    check("nolock_stage", 32'(bus.rst_stage), ALL_ONES);
    check("nolock_retry", 32'(bus.retry_cnt), MAX_RETRY);
    cyc(1'b0, 1'b1);
    check("restart_fail_clear", 32'(bus.fail), 0);
    check("restart_retry_clear", 32'(bus.retry_cnt), 0);

    // Restart coinciding with the final timeout.
    hit = 1'b0;
    n = 0;
    while (!hit && n < 17000) begin
      rq_v = (m_mode == M_WAIT && m_tries == MAX_RETRY && m_t == LOCK_TIMEOUT - 1);
      if (rq_v) check("collision_pre_retry", 32'(bus.retry_cnt), MAX_RETRY);
      cyc(1'b0, rq_v);
      hit = rq_v;
      n++;
    end
    check("collision_reached", 32'(hit), 1);
    check("collision_fail", 32'(bus.fail), 0);
    check("collision_retry", 32'(bus.retry_cnt), 0);
    check("collision_pll_reset_n", 32'(bus.pll_reset_n), 0);

    // Randomized lock drops and restarts.
    drop_left = 0;
    for (int k = 0; k < 6000; k++) begin
      if (drop_left > 0) drop_left--;
      else if ($urandom_range(0, 399) == 0) drop_left = $urandom_range(1, 6);
      lk_v = (drop_left == 0);
      rq_v = ($urandom_range(0, 1499) == 0);
      cyc(lk_v, rq_v);
    end

    // Asynchronous reset in the middle of the release phase.
    cyc(1'b1, 1'b1);
    n = 0;
    while (!(bus.rst_stage[0] === 1'b0 && bus.ready === 1'b0) && n < 600) begin
      cyc(1'b1, 1'b0); n++;
    end
    check("midrel_stage0_cleared", 32'(bus.rst_stage[0]), 0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    model_reset();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
